// File: rtl/axi_write_responder_if.sv
// AXI write-channel bundle (AW, W, B) shared by the responder and its master.
interface axi_write_responder_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
);
  logic [AW-1:0]   axi_awaddr;
  logic [7:0]      axi_awlen;
  logic [2:0]      axi_awsize;
  logic [1:0]      axi_awburst;
  logic            axi_awvalid;
  logic            axi_awready;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wlast;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [1:0]      axi_bresp;
  logic            axi_bvalid;
  logic            axi_bready;

  modport master (
    output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid
  );

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/axi_write_responder.sv
// Single-outstanding AXI write slave: accepts one AW/W burst, drives a registered
// local memory-write port and returns the B response.
module axi_write_responder #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic                clk,
  input  logic                resetn,
  axi_write_responder_if.slave axi,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic [DW/8-1:0]     mem_wstrb
);
  localparam int unsigned SW      = DW / 8;
  localparam int unsigned LOG2_SW = $clog2(SW);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [7:0]      beat_cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic            err_q;
  logic            dec_err_q;
  logic            awready_q;
  logic            wready_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [SW-1:0]   mem_wstrb_q;

  logic [AW-1:0]   inc_c;
  logic [AW-1:0]   wrap_mask_c;
  logic [AW-1:0]   addr_d;
  logic            aw_dec_err_c;
  logic            beat_c;
  logic            last_beat_c;
  logic            wlast_err_c;

  // Next beat address and AW decode checks.
  always_comb begin
    inc_c        = AW'(1) << size_q;
    wrap_mask_c  = ((AW'({1'b0, len_q}) + AW'(1)) << size_q) - AW'(1);
    addr_d       = addr_q;
    unique case (burst_q)
      2'b01:   addr_d = addr_q + inc_c;
      2'b10:   addr_d = (addr_q & ~wrap_mask_c) | ((addr_q + inc_c) & wrap_mask_c);
      default: addr_d = addr_q;
    endcase

    aw_dec_err_c = 1'b0;
    if (axi.axi_awburst == 2'b11) aw_dec_err_c = 1'b1;
    if (axi.axi_awsize > 3'(LOG2_SW)) aw_dec_err_c = 1'b1;
    if (axi.axi_awburst == 2'b10) begin
      if (!(axi.axi_awlen == 8'd1 || axi.axi_awlen == 8'd3 ||
            axi.axi_awlen == 8'd7 || axi.axi_awlen == 8'd15)) aw_dec_err_c = 1'b1;
      if ((axi.axi_awaddr & ((AW'(1) << axi.axi_awsize) - AW'(1))) != '0) aw_dec_err_c = 1'b1;
    end

    beat_c      = axi.axi_wvalid && wready_q;
    last_beat_c = (beat_cnt_q == len_q);
    wlast_err_c = (axi.axi_wlast != last_beat_c);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      dec_err_q   <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          awready_q <= 1'b1;
          if (axi.axi_awvalid && awready_q) begin
            addr_q     <= axi.axi_awaddr;
            len_q      <= axi.axi_awlen;
            size_q     <= axi.axi_awsize;
            burst_q    <= axi.axi_awburst;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            dec_err_q  <= aw_dec_err_c;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (beat_c) begin
            mem_we_q    <= !dec_err_q;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= axi.axi_wdata;
            mem_wstrb_q <= axi.axi_wstrb;
            if (wlast_err_c) err_q <= 1'b1;
            if (last_beat_c) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || wlast_err_c || dec_err_q) ? 2'b10 : 2'b00;
              state_q  <= RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
              addr_q     <= addr_d;
            end
          end
        end
        RESP: begin
          // Response held until accepted; AW reopens the following cycle.
          if (axi.axi_bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axi.axi_awready = awready_q;
  assign axi.axi_wready  = wready_q;
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bresp   = bresp_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_wstrb       = mem_wstrb_q;
endmodule

// File: tb/tb_axi_write_responder.sv
// Bench for axi_write_responder: directed scenarios plus randomized bursts
// checked against an arithmetic address/response model.
module tb_axi_write_responder;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  axi_write_responder_if #(.AW(AW), .DW(DW)) bus ();
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;

  axi_write_responder #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn), .axi(bus),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] mon_addr[$];
  logic [DW-1:0] mon_data[$];
  logic [SW-1:0] mon_strb[$];
  logic [DW-1:0] sent_data[$];
  logic [SW-1:0] sent_strb[$];

  always @(negedge clk) begin
    if (resetn === 1'b1 && mem_we === 1'b1) begin
      mon_addr.push_back(mem_addr);
      mon_data.push_back(mem_wdata);
      mon_strb.push_back(mem_wstrb);
    end
  end

  // Reference model: address of beat i, computed from the burst rules directly.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] addr, input int len,
                                             input int size, input logic [1:0] burst, input int i);
    longint bytes, total, base, a;
    bytes = longint'(1) << size;
    a     = longint'(addr);
    case (burst)
      2'b01:   return AW'((a + i * bytes) % (longint'(1) << AW));
      2'b10: begin
        total = (len + 1) * bytes;
        base  = a - (a % total);
        return AW'(base + ((a - base) + i * bytes) % total);
      end
      default: return addr;
    endcase
  endfunction

  function automatic bit exp_dec_err(input logic [AW-1:0] addr, input int len,
                                     input int size, input logic [1:0] burst);
    if (burst == 2'b11) return 1'b1;
    if (size > 3) return 1'b1;
    if (burst == 2'b10) begin
      if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
      if ((longint'(addr) % (longint'(1) << size)) != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void clear_queues();
    mon_addr.delete(); mon_data.delete(); mon_strb.delete();
    sent_data.delete(); sent_strb.delete();
  endfunction

  // Drives one full burst. wlast_at: -2 = correct wlast, else beat index carrying wlast (-1 none).
  task automatic drive_burst(input logic [AW-1:0] addr, input int len, input int size,
                             input logic [1:0] burst, input int wlast_at, input int max_gap,
                             input int bready_delay, input bit bready_early,
                             output logic [1:0] bresp, output bit bvalid_ok,
                             output bit stable_ok, output bit awready_after);
    int n;
    @(negedge clk);
    bus.axi_awaddr  = addr;
    bus.axi_awlen   = 8'(len);
    bus.axi_awsize  = 3'(size);
    bus.axi_awburst = burst;
    bus.axi_awvalid = 1'b1;
    bus.axi_bready  = bready_early;
    n = 0;
    while (bus.axi_awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL aw_timeout: awready never rose (got %b, need 1)", bus.axi_awready);
    end
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin bus.axi_wvalid = 1'b0; @(negedge clk); end
      bus.axi_wvalid = 1'b1;
      bus.axi_wdata  = {$urandom, $urandom};
      bus.axi_wstrb  = SW'($urandom);
      bus.axi_wlast  = (wlast_at == -2) ? (i == len) : (i == wlast_at);
      sent_data.push_back(bus.axi_wdata);
      sent_strb.push_back(bus.axi_wstrb);
      n = 0;
      while (bus.axi_wready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
        vectors++; miscompares++;
        $display("FAIL w_timeout: wready never rose on beat %0d (got %b, need 1)", i, bus.axi_wready);
      end
      @(negedge clk);
    end
    bus.axi_wvalid = 1'b0;
    bus.axi_wlast  = 1'b0;
    bvalid_ok = (bus.axi_bvalid === 1'b1);
    bresp     = bus.axi_bresp;
    stable_ok = 1'b1;
    if (!bready_early) begin
      for (int d = 0; d < bready_delay; d++) begin
        @(negedge clk);
        if (bus.axi_bvalid !== 1'b1 || bus.axi_bresp !== bresp) stable_ok = 1'b0;
      end
      bus.axi_bready = 1'b1;
    end
    @(negedge clk);
    bus.axi_bready = 1'b0;
    awready_after = (bus.axi_awready === 1'b1) && (bus.axi_bvalid === 1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.axi_awready, bus.axi_wready, bus.axi_bvalid, bus.axi_bresp, mem_we, mem_addr,
         mem_wdata, mem_wstrb} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got aw=%b w=%b b=%b we=%b, need all 0",
               bus.axi_awready, bus.axi_wready, bus.axi_bvalid, mem_we);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.axi_awready !== 1'b1 || bus.axi_wready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got awready=%b wready=%b, need 1/0", bus.axi_awready, bus.axi_wready);
    end
  endtask

  task automatic test_incr_single();
    logic [1:0] br; bit bv, st, aa;
    clear_queues();
    drive_burst(32'h100, 0, 3, 2'b01, -2, 0, 0, 1'b1, br, bv, st, aa);
    vectors++;
    if (mon_addr.size() != 1 || mon_addr[0] !== 32'h100 || mon_data[0] !== sent_data[0]) begin
      miscompares++;
      $display("FAIL single_write: got %0d writes addr=%h, need 1 write at 100", mon_addr.size(),
               (mon_addr.size() > 0) ? mon_addr[0] : 32'hx);
    end
    vectors++;
    if (!bv || br !== 2'b00) begin
      miscompares++;
      $display("FAIL single_bresp: got bvalid=%b bresp=%b, need 1/00", bv, br);
    end
    vectors++;
    if (!aa) begin
      miscompares++;
      $display("FAIL single_idle: got awready/!bvalid=%b after B, need 1", aa);
    end
  endtask

  task automatic test_incr_gaps();
    logic [1:0] br; bit bv, st, aa;
    logic [AW-1:0] exp[4];
    exp = '{32'h200, 32'h208, 32'h210, 32'h218};
    clear_queues();
    drive_burst(32'h200, 3, 3, 2'b01, -2, 2, 3, 1'b0, br, bv, st, aa);
    vectors++;
    if (mon_addr.size() != 4) begin
      miscompares++;
      $display("FAIL gaps_count: got %0d writes, need 4", mon_addr.size());
    end
    for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
      vectors++;
      if (mon_addr[i] !== exp[i] || mon_data[i] !== sent_data[i] || mon_strb[i] !== sent_strb[i]) begin
        miscompares++;
        $display("FAIL gaps_beat%0d: got addr=%h, need %h", i, mon_addr[i], exp[i]);
      end
    end
    vectors++;
    if (!bv || !st || br !== 2'b00) begin
      miscompares++;
      $display("FAIL gaps_bresp: got bvalid=%b stable=%b bresp=%b, need 1/1/00", bv, st, br);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] br; bit bv, st, aa;
    logic [AW-1:0] exp[4];
    exp = '{32'h1018, 32'h1000, 32'h1008, 32'h1010};
    clear_queues();
    drive_burst(32'h1018, 3, 3, 2'b10, -2, 0, 1, 1'b0, br, bv, st, aa);
    vectors++;
    if (mon_addr.size() != 4 || br !== 2'b00) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d writes bresp=%b, need 4/00", mon_addr.size(), br);
    end
    for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
      vectors++;
      if (mon_addr[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL wrap_beat%0d: got addr=%h, need %h", i, mon_addr[i], exp[i]);
      end
    end
  endtask

  // Table: FIXED len 2, early wlast, missing wlast, then decode errors.
  task automatic test_fixed_and_errors();
    logic [AW-1:0] t_addr[6];
    int t_len[6], t_size[6], t_wl[6], t_nw[6];
    logic [1:0] t_burst[6], t_resp[6];
    logic [1:0] br; bit bv, st, aa;
    t_addr  = '{32'h40, 32'h80, 32'hC0, 32'h300, 32'h400, 32'h500};
    t_len   = '{2, 3, 1, 3, 1, 2};
    t_size  = '{3, 3, 3, 3, 4, 3};
    t_burst = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b10};
    t_wl    = '{-2, 1, -1, -2, -2, -2};
    t_nw    = '{3, 4, 2, 0, 0, 0};
    t_resp  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    for (int c = 0; c < 6; c++) begin
      clear_queues();
      drive_burst(t_addr[c], t_len[c], t_size[c], t_burst[c], t_wl[c], 1, 1, 1'b0, br, bv, st, aa);
      vectors++;
      if (mon_addr.size() != t_nw[c] || br !== t_resp[c] || !bv) begin
        miscompares++;
        $display("FAIL err_case%0d: got %0d writes bresp=%b bvalid=%b, need %0d/%b/1",
                 c, mon_addr.size(), br, bv, t_nw[c], t_resp[c]);
      end
      for (int i = 0; i < mon_addr.size() && i < t_nw[c]; i++) begin
        vectors++;
        if (mon_addr[i] !== exp_addr(t_addr[c], t_len[c], t_size[c], t_burst[c], i)) begin
          miscompares++;
          $display("FAIL err_case%0d_beat%0d: got addr=%h, need %h", c, i, mon_addr[i],
                   exp_addr(t_addr[c], t_len[c], t_size[c], t_burst[c], i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] br; bit bv, st, aa;
    int n;
    @(negedge clk);
    bus.axi_awaddr = 32'h600; bus.axi_awlen = 8'd7; bus.axi_awsize = 3'd3;
    bus.axi_awburst = 2'b01; bus.axi_awvalid = 1'b1;
    n = 0;
    while (bus.axi_awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid = 1'b1; bus.axi_wdata = 64'h1; bus.axi_wstrb = 8'hFF; bus.axi_wlast = 1'b0;
    repeat (2) @(negedge clk);
    bus.axi_wvalid = 1'b0;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({bus.axi_awready, bus.axi_wready, bus.axi_bvalid, bus.axi_bresp, mem_we, mem_addr,
         mem_wdata, mem_wstrb} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got aw=%b w=%b b=%b we=%b, need all 0",
               bus.axi_awready, bus.axi_wready, bus.axi_bvalid, mem_we);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_queues();
    n = 0;
    while (bus.axi_awready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (bus.axi_awready !== 1'b1 || bus.axi_bvalid !== 1'b0 || mon_addr.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_idle: got awready=%b bvalid=%b writes=%0d, need 1/0/0",
               bus.axi_awready, bus.axi_bvalid, mon_addr.size());
    end
    drive_burst(32'h700, 1, 2, 2'b01, -2, 0, 0, 1'b0, br, bv, st, aa);
    vectors++;
    if (mon_addr.size() != 2 || br !== 2'b00 || !bv || mon_addr[1] !== 32'h704) begin
      miscompares++;
      $display("FAIL midreset_recover: got %0d writes bresp=%b, need 2/00 at 700,704",
               mon_addr.size(), br);
    end
  endtask

  task automatic test_random();
    logic [1:0] br; bit bv, st, aa;
    logic [AW-1:0] addr;
    logic [1:0] burst;
    int len, size, wl, nw;
    bit dec, exp_err;
    for (int r = 0; r < 30; r++) begin
      burst = ($urandom_range(9, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
      size  = ($urandom_range(7, 0) == 0) ? 4 : int'($urandom_range(3, 0));
      if (burst == 2'b10 && $urandom_range(4, 0) != 0) len = (2 << $urandom_range(3, 0)) - 1;
      else len = int'($urandom_range(7, 0));
      addr = $urandom;
      if ($urandom_range(4, 0) != 0) addr = addr & ~((AW'(1) << size) - AW'(1));
      if (r % 7 == 3) addr = 32'hFFFF_FFF0;
      wl = ($urandom_range(5, 0) == 0) ? int'($urandom_range(len + 1, 0)) - 1 : -2;
      dec     = exp_dec_err(addr, len, size, burst);
      exp_err = dec || (wl != -2 && wl != len);
      nw      = dec ? 0 : len + 1;
      clear_queues();
      drive_burst(addr, len, size, burst, wl, 2, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                  br, bv, st, aa);
      vectors++;
      if (mon_addr.size() != nw || br !== (exp_err ? 2'b10 : 2'b00) || !bv || !st || !aa) begin
        miscompares++;
        $display("FAIL rnd%0d: got %0d writes bresp=%b bv=%b st=%b idle=%b, need %0d/%b/1/1/1",
                 r, mon_addr.size(), br, bv, st, aa, nw, exp_err ? 2'b10 : 2'b00);
      end
      for (int i = 0; i < mon_addr.size() && i < nw; i++) begin
        vectors++;
        if (mon_addr[i] !== exp_addr(addr, len, size, burst, i) ||
            mon_data[i] !== sent_data[i] || mon_strb[i] !== sent_strb[i]) begin
          miscompares++;
          $display("FAIL rnd%0d_beat%0d: got addr=%h data=%h, need %h %h", r, i, mon_addr[i],
                   mon_data[i], exp_addr(addr, len, size, burst, i), sent_data[i]);
        end
      end
    end
  endtask

  initial begin
    resetn          = 1'b0;
    bus.axi_awaddr  = '0;
    bus.axi_awlen   = '0;
    bus.axi_awsize  = '0;
    bus.axi_awburst = '0;
    bus.axi_awvalid = 1'b0;
    bus.axi_wdata   = '0;
    bus.axi_wstrb   = '0;
    bus.axi_wlast   = 1'b0;
    bus.axi_wvalid  = 1'b0;
    bus.axi_bready  = 1'b0;
    test_reset();
    test_incr_single();
    test_incr_gaps();
    test_wrap();
    test_fixed_and_errors();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
